if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID capture, redirect/flush, halt
// detection and an IDLE/RUN/STEP/HALTED control FSM.
// Optional single-step debug mode is compiled in with `define IF_DEBUG_STEP_EN.
module if_fetch_unit #(
    parameter int unsigned NB_PC       = 32,
    parameter int unsigned NB_DATA_BUS = 32,
    parameter int unsigned N_ADDRESS   = 64,
    parameter int unsigned NB_ADDRESS  = $clog2(N_ADDRESS),
    parameter logic [NB_DATA_BUS-1:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [NB_DATA_BUS-1:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_stall,
    input  logic                   i_branch_taken,
    input  logic [NB_PC-1:0]       i_branch_target,
    input  logic                   i_jump,
    input  logic [NB_PC-1:0]       i_jump_target,
    input  logic                   i_dbg_step_mode,
    input  logic                   i_dbg_step,
    input  logic [NB_DATA_BUS-1:0] i_rom_data,
    output logic [NB_ADDRESS-1:0]  o_rom_addr,
    output logic                   o_rom_en,
    output logic [NB_DATA_BUS-1:0] o_instr,
    output logic [NB_PC-1:0]       o_pc_plus4,
    output logic                   o_valid,
    output logic                   o_halted,
    output logic [31:0]            o_fetch_count
);

`ifdef IF_DEBUG_STEP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2, S_STEP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2} state_t;
`endif

    state_t                 r_state;
    logic [NB_PC-1:0]       r_pc;
    logic [NB_DATA_BUS-1:0] r_instr;
    logic [NB_PC-1:0]       r_pc_plus4;
    logic                   r_valid;
    logic                   r_halted;
    logic [31:0]            r_fetch_count;

    logic                   w_in_step;
    logic                   w_step_go;
    logic                   w_mode;
    logic                   w_active;
    logic                   w_redirect;
    logic                   w_seq_adv;
    logic                   w_halt;
    logic [NB_PC-1:0]       w_target;
    logic [NB_PC-1:0]       w_pc_plus4;

`ifdef IF_DEBUG_STEP_EN
    // Step state advances only on a step pulse
    assign w_in_step = (r_state == S_STEP);
    assign w_step_go = w_in_step && i_dbg_step;
    assign w_mode    = i_dbg_step_mode;
`else
    // Debug inputs are kept as ports but have no effect
    logic w_unused_dbg;
    assign w_unused_dbg = i_dbg_step_mode ^ i_dbg_step;
    assign w_in_step    = 1'b0;
    assign w_step_go    = 1'b0;
    assign w_mode       = 1'b0;
`endif

    // Fetch qualification, redirect selection and halt detection
    assign w_active   = (r_state == S_RUN) || w_in_step;
    assign w_redirect = w_active && (i_branch_taken || i_jump);
    assign w_target   = (i_branch_taken ? i_branch_target : i_jump_target) & ~NB_PC'(3);
    assign w_pc_plus4 = r_pc + NB_PC'(4);
    assign w_seq_adv  = w_active && !w_redirect && !i_stall &&
                        ((r_state == S_RUN) || w_step_go);
    assign w_halt     = w_seq_adv && (i_rom_data == HALT_INSTR);

    // Memory reads on the falling edge, so the address comes straight from the PC
    assign o_rom_addr    = r_pc[NB_ADDRESS+1:2];
    assign o_rom_en      = w_active && !i_stall;
    assign o_instr       = r_instr;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;
    assign o_halted      = r_halted;
    assign o_fetch_count = r_fetch_count;

    // Control FSM plus PC and IF/ID register updates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instr       <= NOP_INSTR;
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef IF_DEBUG_STEP_EN
                    if (i_start) r_state <= w_mode ? S_STEP : S_RUN;
`else
                    if (i_start) r_state <= S_RUN;
`endif
                end
                S_RUN: begin
`ifdef IF_DEBUG_STEP_EN
                    if (w_mode) r_state <= S_STEP;
`endif
                end
`ifdef IF_DEBUG_STEP_EN
                S_STEP: begin
                    if (!w_mode) r_state <= S_RUN;
                end
`endif
                S_HALTED: begin
                    r_valid <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_redirect) begin
                r_pc    <= w_target;
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (w_seq_adv) begin
                r_instr       <= i_rom_data;
                r_pc_plus4    <= w_pc_plus4;
                r_valid       <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
                if (w_halt) begin
                    r_state  <= S_HALTED;
                    r_halted <= 1'b1;
                end else begin
                    r_pc <= w_pc_plus4;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a capture scoreboard.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic        dbg_mode;
    logic        dbg_step;
    logic [31:0] rom_data;
    logic [5:0]  rom_addr;
    logic        rom_en;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] fcount;

    logic [31:0] mem [64];

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_cnt = 0;

    if_fetch_unit dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_stall         (stall),
        .i_branch_taken  (br),
        .i_branch_target (br_tgt),
        .i_jump          (jmp),
        .i_jump_target   (jmp_tgt),
        .i_dbg_step_mode (dbg_mode),
        .i_dbg_step      (dbg_step),
        .i_rom_data      (rom_data),
        .o_rom_addr      (rom_addr),
        .o_rom_en        (rom_en),
        .o_instr         (instr),
        .o_pc_plus4      (pc4),
        .o_valid         (valid),
        .o_halted        (halted),
        .o_fetch_count   (fcount)
    );

    assign rom_data = mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [31:0] c);
        exp_t e;
        e.instr = i;
        e.pc4   = p;
        e.cnt   = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0; start = 0; stall = 0; br = 0; jmp = 0; dbg_mode = 0; dbg_step = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: each new valid capture (count change) is checked against the scoreboard
    always @(negedge clk) begin
        if (fcount == 32'd0) begin
            last_cnt = 32'd0;
        end else if (fcount != last_cnt) begin
            last_cnt = fcount;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%h required=no_capture", instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cap_instr", instr, e.instr);
                chk("cap_pc4", pc4, e.pc4);
                chk("cap_cnt", fcount, e.cnt);
                chk("cap_valid", 32'(valid), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'hFFFF_FFFF;
        rst_n = 0; start = 0; stall = 0; br = 0; jmp = 0; dbg_mode = 0; dbg_step = 0;
        br_tgt = 0; jmp_tgt = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc4", pc4, 0);
        chk("rst_cnt", fcount, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_rom_en", 32'(rom_en), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        rst_n = 1;
        tick();
        tick();
        chk("idle_rom_en", 32'(rom_en), 0);
        chk("idle_cnt", fcount, 0);

        // Sequential run to halt
        push(32'h11, 4, 1); push(32'h22, 8, 2); push(32'h33, 12, 3); push(32'hFFFF_FFFF, 16, 4);
        start = 1;
        tick();
        start = 0;
        chk("run_rom_en", 32'(rom_en), 1);
        repeat (4) tick();
        chk("halt_flag", 32'(halted), 1);
        chk("halt_instr", instr, 32'hFFFF_FFFF);
        chk("halt_pc_addr", 32'(rom_addr), 3);
        tick();
        chk("halt_valid_drop", 32'(valid), 0);
        chk("halt_rom_en", 32'(rom_en), 0);
        chk("halt_cnt_hold", fcount, 4);
        chk("halt_pc_hold", 32'(rom_addr), 3);
        chk("halt_pc4_hold", pc4, 16);

        // Stall at pc=8
        do_reset();
        push(32'h11, 4, 1); push(32'h22, 8, 2);
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_addr", 32'(rom_addr), 2);
            chk("stall_rom_en", 32'(rom_en), 0);
            chk("stall_instr", instr, 32'h22);
            chk("stall_cnt", fcount, 2);
        end
        stall = 0;
        push(32'h33, 12, 3); push(32'hFFFF_FFFF, 16, 4);
        repeat (3) tick();
        chk("stall_halted", 32'(halted), 1);

        // Branch beats jump, even under stall
        do_reset();
        push(32'h11, 4, 1);
        start = 1;
        tick();
        start = 0;
        tick();
        br = 1; br_tgt = 32'h20; jmp = 1; jmp_tgt = 32'h40; stall = 1;
        tick();
        br = 0; jmp = 0; stall = 0;
        chk("redir_addr", 32'(rom_addr), 8);
        chk("redir_valid", 32'(valid), 0);
        chk("redir_instr", instr, 32'h0);
        chk("redir_cnt", fcount, 1);
        push(32'h108, 32'h24, 2);
        tick();

        // Misaligned jump target aliasing to word 0
        jmp = 1; jmp_tgt = 32'h103;
        tick();
        jmp = 0;
        chk("alias_addr", 32'(rom_addr), 0);
        chk("alias_valid", 32'(valid), 0);
        push(32'h11, 32'h104, 3);
        tick();

        // Async reset between edges while running at pc=0x0C
        do_reset();
        push(32'h11, 4, 1); push(32'h22, 8, 2); push(32'h33, 12, 3);
        start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        stall = 1;
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("arst_rom_en", 32'(rom_en), 0);
        chk("arst_addr", 32'(rom_addr), 0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_pc4", pc4, 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_cnt", fcount, 0);
        chk("arst_halted", 32'(halted), 0);
        stall = 0;
        tick();
        rst_n = 1;
        tick();
        chk("arst_idle", 32'(rom_en), 0);
        push(32'h11, 4, 1);
        start = 1;
        tick();
        start = 0;
        tick();
        chk("arst_restart_addr", 32'(rom_addr), 1);

`ifdef IF_DEBUG_STEP_EN
        // Single-step: one capture per pulse
        do_reset();
        dbg_mode = 1;
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        chk("step_wait_cnt", fcount, 0);
        chk("step_wait_addr", 32'(rom_addr), 0);
        chk("step_rom_en", 32'(rom_en), 1);
        push(32'h11, 4, 1);
        dbg_step = 1;
        tick();
        dbg_step = 0;
        tick();
        tick();
        chk("step_one_cnt", fcount, 1);
        chk("step_one_addr", 32'(rom_addr), 1);
`else
        // Debug inputs ignored: start enters RUN regardless
        do_reset();
        dbg_mode = 1;
        push(32'h11, 4, 1);
        start = 1;
        tick();
        start = 0;
        tick();
        chk("nostep_run_cnt", fcount, 1);
`endif
        do_reset();
        tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
